iterative_alu: RTL and testbench
================================

ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset; one clock, synchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1, request to execute one operation.
REQ-005 The block SHALL have port alu_operation_i, input, 4, operation code from ALU control.
REQ-006 The block SHALL have port a_i, input, 32, operand A (rs).
REQ-007 The block SHALL have port b_i, input, 32, operand B (rt or extended immediate).
REQ-008 The block SHALL have port shamt_i, input, 5, shift amount.
REQ-009 The block SHALL have port busy_o, output, 1, high while a shift is iterating.
REQ-010 The block SHALL have port done_o, output, 1, one-cycle pulse; result valid.
REQ-011 The block SHALL have port result_o, output, 32, registered result.
REQ-012 The block SHALL have port zero_o, output, 1, registered (result == 0).
REQ-013 The block SHALL have port invalid_o, output, 1, registered; high when last completed code was unsupported.

Function
REQ-014 Op codes SHALL be: 0000 LUI {B[15:0],16'h0}; 0001 OR; 0010 SLL B<<shamt; 0011 ADD; 0100 SRL B>>shamt (logical); 0101 SUB A-B; 0110 AND; 0111 NOR; all other codes invalid.
REQ-015 ADD/SUB SHALL wrap modulo 2^32; no overflow or carry output.
REQ-016 State machine SHALL have states IDLE, SHIFT, DONE.
REQ-017 start_i SHALL be accepted only when busy_o=0 (state IDLE or DONE); ignored in SHIFT.
REQ-018 On acceptance at cycle N, a_i, b_i, shamt_i and alu_operation_i SHALL be captured; later input changes have no effect.
REQ-019 Non-shift, invalid, and shifts with shamt=0: next state DONE; done_o=1 in cycle N+1.
REQ-020 Shift with shamt=k>0: SHIFT for cycles N+1..N+k, one bit per cycle, counter decrements from k; DONE in cycle N+k+1.
REQ-021 busy_o SHALL be 1 exactly in SHIFT state.
REQ-022 DONE SHALL last one cycle then go to IDLE, unless start_i is accepted in DONE (back-to-back), in which case it follows REQ-019/020.
REQ-023 result_o, zero_o, invalid_o SHALL update only in the cycle done_o rises and hold until the next done_o.
REQ-024 Invalid code SHALL produce result_o=0, zero_o=1, invalid_o=1; valid codes set invalid_o=0.

Reset
REQ-025 reset SHALL force state IDLE, busy_o=0, done_o=0, result_o=0, zero_o=0, invalid_o=0, shift counter=0.
REQ-026 Reset during SHIFT SHALL abandon the operation; no done_o pulse follows.
REQ-027 reset SHALL dominate start_i in the same cycle.

Structure
REQ-028 Op-code constants and state encoding SHALL live in shared package alu_pkg, also used by the ALU control decoder.
REQ-029 The iterative shifter (shift register, 5-bit down-counter, direction select) SHALL be sub-module alu_shift_unit.

Verification
REQ-030 ADD A=32'hFFFF_FFFF, B=1, start at N -> done_o at N+1, result 0, zero_o=1, invalid_o=0.
REQ-031 SLL B=32'h0000_0001, shamt=31 -> busy_o N+1..N+31, done_o N+32, result 32'h8000_0000.
REQ-032 SRL B=32'h8000_0000, shamt=4, start_i re-pulsed during SHIFT -> ignored; done_o N+5, result 32'h0800_0000, single done_o.
REQ-033 LUI B=32'h0000_1234 then SUB A=5,B=7 started in DONE cycle -> results 32'h1234_0000 then 32'hFFFF_FFFE on consecutive done_o.
REQ-034 Code 4'b1001 -> done_o N+1, result 0, zero_o=1, invalid_o=1.
REQ-035 SLL shamt=10, reset asserted at N+3 -> outputs reset values from N+4, no done_o within 20 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, FSM state encoding and the combinational result helper.
// Latency: none. These are constants and pure functions only.
// Backpressure: not applicable.
// Used by the ALU control decoder and by iterative_alu / alu_shift_unit.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_LUI = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  // Single-cycle result. Shifts return B unchanged: this path is only taken
  // for shamt == 0, and non-zero shifts go through the iterative unit.
  function automatic logic [XLEN-1:0] alu_eval(input logic [3:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_LUI:         r = {b[15:0], 16'h0000};
      OP_OR:          r = a | b;
      OP_ADD:         r = a + b;
      OP_SUB:         r = a - b;
      OP_AND:         r = a & b;
      OP_NOR:         r = ~(a | b);
      OP_SLL, OP_SRL: r = b;
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: it loads B, the shift amount and the direction, then shifts one bit per step.
// Latency: one bit per asserted step cycle, so a shift of k bits takes k steps.
// Backpressure: none. The parent sequences load and step.
// Ports: clk and reset; load, with data, shamt and shift_right, loads the unit; step advances it.
//        last is high when the current step is the final one.
//        next_value is the register value after the current step.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  shift_right,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [4:0]            shamt,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] next_value
);

  logic [DATA_WIDTH-1:0] value_q;
  logic [4:0]            count_q;
  logic                  right_q;

  assign next_value = right_q ? {1'b0, value_q[DATA_WIDTH-1:1]}
                              : {value_q[DATA_WIDTH-2:0], 1'b0};
  assign last       = (count_q == 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      count_q <= 5'd0;
      right_q <= 1'b0;
    end else if (load) begin
      value_q <= data;
      count_q <= shamt;
      right_q <= shift_right;
    end else if (step && (count_q != 5'd0)) begin
      value_q <= next_value;
      count_q <= count_q - 5'd1;
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle ALU. Operations other than shifts finish in one cycle; shifts finish one bit per cycle.
// Latency: done_o arrives one cycle after start, or shamt+1 cycles after start for a shift with shamt > 0.
// Backpressure: start_i is ignored while busy_o is high. A start in the DONE cycle is accepted back-to-back.
// Ports: clk and reset; start_i with alu_operation_i, a_i, b_i and shamt_i form the request.
//        busy_o, done_o, result_o, zero_o and invalid_o report status and the result.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [4:0]            shamt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  invalid_o
);

  alu_state_t            state_q, state_nxt;
  logic [DATA_WIDTH-1:0] result_q, res_nxt;
  logic                  zero_q, invalid_q;
  logic                  load_res, inv_nxt;
  logic                  shift_load, shift_step;
  logic                  shift_last;
  logic [DATA_WIDTH-1:0] shift_next;

  alu_shift_unit #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .clk         (clk),
    .reset       (reset),
    .load        (shift_load),
    .step        (shift_step),
    .shift_right (alu_operation_i == OP_SRL),
    .data        (b_i),
    .shamt       (shamt_i),
    .last        (shift_last),
    .next_value  (shift_next)
  );

  always_comb begin
    state_nxt  = state_q;
    load_res   = 1'b0;
    res_nxt    = '0;
    inv_nxt    = 1'b0;
    shift_load = 1'b0;
    shift_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start_i) begin
          if (op_is_shift(alu_operation_i) && (shamt_i != 5'd0)) begin
            shift_load = 1'b1;
            state_nxt  = ST_SHIFT;
          end else begin
            state_nxt = ST_DONE;
            load_res  = 1'b1;
            res_nxt   = alu_eval(alu_operation_i, a_i, b_i);
            inv_nxt   = !op_is_valid(alu_operation_i);
          end
        end
      end
      ST_SHIFT: begin
        shift_step = 1'b1;
        // The final bit is taken straight from the shifter so that the
        // result lands together with the entry into DONE.
        if (shift_last) begin
          state_nxt = ST_DONE;
          load_res  = 1'b1;
          res_nxt   = shift_next;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (load_res) begin
        result_q  <= res_nxt;
        zero_q    <= (res_nxt == '0);
        invalid_q <= inv_nxt;
      end
    end
  end

  assign busy_o    = (state_q == ST_SHIFT);
  assign done_o    = (state_q == ST_DONE);
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign invalid_o = invalid_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu. It runs the directed cases, then random operations checked against a reference model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_iterative_alu;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  shamt_i;
  logic        busy_o, done_o, zero_o, invalid_o;
  logic [31:0] result_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_res;
  logic        m_zero, m_inv;

  iterative_alu #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .shamt_i         (shamt_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .invalid_o       (invalid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model, computed directly from the operation table.
  function automatic logic ref_valid(input logic [3:0] op);
    return op <= 4'd7;
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return (b & 32'h0000_FFFF) * 32'd65536;
      4'd1: return a | b;
      4'd2: return b << sh;
      4'd3: return a + b;
      4'd4: return b >> sh;
      4'd5: return a - b;
      4'd6: return a & b;
      4'd7: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // The caller is positioned at a negedge in cycle N. This task issues the
  // request and returns at the negedge of the done cycle, with start_i low.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit repulse);
    logic [31:0] er;
    int lat;
    er  = ref_res(op, a, b, sh);
    lat = ((op == 4'd2 || op == 4'd4) && sh != 0) ? int'(sh) + 1 : 1;
    start_i = 1'b1; alu_operation_i = op; a_i = a; b_i = b; shamt_i = sh;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("busy", {31'd0, busy_o}, {31'd0, (i < lat)});
      chk("done", {31'd0, done_o}, {31'd0, (i == lat)});
      if (i < lat) chk("hold_result", result_o, m_res);
      // Scramble the inputs so that a missing capture shows up as a wrong result.
      start_i = repulse && (i < lat);
      alu_operation_i = 4'($urandom); a_i = $urandom; b_i = $urandom; shamt_i = 5'($urandom);
    end
    m_res = er; m_zero = (er == 32'd0); m_inv = !ref_valid(op);
    chk("result", result_o, m_res);
    chk("zero", {31'd0, zero_o}, {31'd0, m_zero});
    chk("invalid", {31'd0, invalid_o}, {31'd0, m_inv});
  endtask

  task automatic idle();
    @(negedge clk);
    start_i = 1'b0;
    chk("done_single", {31'd0, done_o}, 32'd0);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("result_held", result_o, m_res);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; alu_operation_i = 4'd0; a_i = 32'd0; b_i = 32'd0; shamt_i = 5'd0;
    m_res = 32'd0; m_zero = 1'b0; m_inv = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd0);
    chk("rst_invalid", {31'd0, invalid_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);  idle();
    run_op(4'd2, 32'h1234_5678, 32'd1, 5'd31, 1'b0); idle();
    run_op(4'd4, 32'd0, 32'h8000_0000, 5'd4, 1'b1);  idle();
    run_op(4'd0, 32'd0, 32'h0000_1234, 5'd0, 1'b0);
    run_op(4'd5, 32'd5, 32'd7, 5'd0, 1'b0);          idle();
    run_op(4'b1001, 32'hDEAD_BEEF, 32'h1, 5'd3, 1'b0); idle();
    run_op(4'd2, 32'd0, 32'hA5A5_0001, 5'd0, 1'b0);  idle();
    run_op(4'd7, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b0); idle();

    // Reset in the middle of a shift. reset also wins over a start in the same cycle.
    start_i = 1'b1; alu_operation_i = 4'd2; b_i = 32'd3; shamt_i = 5'd10;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start_i = 1'b0;
      chk("rst_shift_busy", {31'd0, busy_o}, 32'd1);
    end
    reset = 1'b1; start_i = 1'b1; alu_operation_i = 4'd3; a_i = 32'd1; b_i = 32'd1;
    @(negedge clk);
    reset = 1'b0; start_i = 1'b0;
    m_res = 32'd0; m_zero = 1'b0; m_inv = 1'b0;
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_done", {31'd0, done_o}, 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    chk("rst_mid_zero", {31'd0, zero_o}, 32'd0);
    chk("rst_mid_invalid", {31'd0, invalid_o}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done_o}, 32'd0);
      chk("rst_no_busy", {31'd0, busy_o}, 32'd0);
    end

    for (int t = 0; t < 60; t++) begin
      logic [3:0] op;
      op = (t % 3 == 0) ? ((t % 2 == 0) ? 4'd2 : 4'd4) : 4'($urandom_range(0, 15));
      run_op(op, $urandom, $urandom, 5'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
